ustoch_to_bin: RTL

Windowed stochastic-to-binary converter that sits directly downstream of the unipolar scaled adder. It counts the ones in its output bitstream over a programmable window of cycles. The finished count is presented as an unsigned binary value through a valid/ready handshake. Together with the adder it forms the readout path that turns a scaled stochastic sum back into a number for the host or the next binary stage.

---
 rtl/ustoch_pkg.sv | 14 +
 rtl/ustoch_to_bin.sv | 106 ++++++++++
 2 files changed

// File: rtl/ustoch_pkg.sv
// Shared definitions for the stochastic readout path: FSM states and the
// default stream-window exponent used by the scaled adder and the converter.
package ustoch_pkg;

  // log2 of the maximum window length; shared with the upstream adder.
  localparam int unsigned BITW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ustoch_to_bin.sv
// Windowed stochastic-to-binary converter: counts the ones in a bitstream
// over a programmable window and presents the count through valid/ready.
module ustoch_to_bin
  import ustoch_pkg::*;
#(
  parameter int unsigned BITW = BITW_DEF
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iStart,
  input  logic [BITW:0]   iLen,
  input  logic            iClr,
  input  logic            iEn,
  input  logic            iIn,
  output logic            oBusy,
  output logic            oValid,
  input  logic            iReady,
  output logic [BITW:0]   oCnt
);

  state_t          state;
  logic [BITW:0]   acc;
  logic [BITW:0]   remain;
  logic [BITW:0]   eff_len;
  logic [BITW:0]   acc_inc;

  // Window length actually loaded: a zero length field selects 2^BITW.
  always_comb begin
    eff_len = iLen;
    if (iLen == '0) begin
      eff_len = {1'b1, {BITW{1'b0}}};
    end
  end

  // Accumulator value including the bit consumed at this edge.
  always_comb begin
    acc_inc = acc + {{BITW{1'b0}}, iIn};
  end

  // Control FSM with window/ones counters; busy/valid are registered
  // alongside the state so that no input reaches an output combinationally.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      acc    <= '0;
      remain <= '0;
      oCnt   <= '0;
      oBusy  <= 1'b0;
      oValid <= 1'b0;
    end else if (iClr) begin
      state  <= IDLE;
      acc    <= '0;
      remain <= '0;
      oCnt   <= '0;
      oBusy  <= 1'b0;
      oValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state  <= RUN;
            acc    <= '0;
            remain <= eff_len;
            oBusy  <= 1'b1;
          end
        end

        RUN: begin
          if (iEn) begin
            acc    <= acc_inc;
            remain <= remain - 1'b1;
            if (remain == {{BITW{1'b0}}, 1'b1}) begin
              state  <= DONE;
              oCnt   <= acc_inc;
              oBusy  <= 1'b0;
              oValid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            // Handshake and a new request on the same edge chain windows
            // without passing through IDLE.
            if (iStart) begin
              state  <= RUN;
              acc    <= '0;
              remain <= eff_len;
              oBusy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state  <= IDLE;
          oBusy  <= 1'b0;
          oValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
